// File: rtl/mux_pipe_scan.sv
// -----------------------------------------------------------------------------
// mux_pipe_scan
//   Pipelined NUM_IN:1 multiplexer built as a binary tree of 2:1 levels.
//   A register stage follows every LEVELS_PER_STAGE tree levels. The channel
//   index travels down the pipeline with the data, so each stage steers its
//   levels from that stored copy. In scan mode the index comes from an
//   internal counter that walks every channel in turn.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    NUM_IN*WIDTH; channel k at [k*WIDTH +: WIDTH]
//   sel        channel index (mode 0)
//   mode       0 = direct select, 1 = auto scan
//   in_valid   request valid (mode 0)
//   in_ready   pipeline can accept this cycle
//   out_data   selected channel data
//   out_sel    index that produced out_data
//   out_valid  output payload valid
//   out_ready  downstream accepts output
//   out_err    index was >= NUM_IN (out_data forced to 0)
//   out_last   scan item for channel NUM_IN-1
// -----------------------------------------------------------------------------
module mux_pipe_scan #(
  parameter int NUM_IN           = 64,
  parameter int WIDTH            = 1,
  parameter int LEVELS_PER_STAGE = 2,
  localparam int SEL_W           = $clog2(NUM_IN),
  localparam int LAT             = (SEL_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_err,
  output logic                    out_last
);

  // The tree is padded to a power of two; pad channels read as zero, which
  // is exactly what an out-of-range index must return.
  localparam int NPAD = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);
  localparam logic [SEL_W:0]   NUM_IN_X = (SEL_W + 1)'(NUM_IN);

  // Applies tree levels [lo, hi) to a packed channel vector. Survivors are
  // compacted to the low end; the vacated upper part is cleared so the
  // unused register bits of later stages are constant.
  function automatic logic [NPAD*WIDTH-1:0] reduce(
    input logic [NPAD*WIDTH-1:0] v_in,
    input logic [SEL_W-1:0]      idx,
    input int                    lo,
    input int                    hi
  );
    logic [NPAD*WIDTH-1:0] v;
    v = v_in;
    for (int l = 0; l < SEL_W; l++) begin
      if (l >= lo && l < hi) begin
        for (int j = 0; j < NPAD; j++) begin
          if (j < (NPAD >> (l + 1)))
            v[j*WIDTH +: WIDTH] = idx[l] ? v[(2*j+1)*WIDTH +: WIDTH]
                                         : v[(2*j)*WIDTH +: WIDTH];
          else
            v[j*WIDTH +: WIDTH] = '0;
        end
      end
    end
    return v;
  endfunction

  logic                     stall;
  logic                     acc;
  logic [SEL_W-1:0]         acc_idx;
  logic                     acc_err;
  logic                     acc_last;
  logic [SEL_W-1:0]         scan_cnt;
  logic [NPAD*WIDTH-1:0]    pad;

  logic [NPAD*WIDTH-1:0]    dq [LAT];
  logic [SEL_W-1:0]         iq [LAT];
  logic [LAT-1:0]           vq, eq, lq;

  logic [NPAD*WIDTH-1:0]    nd [LAT];
  logic [SEL_W-1:0]         ni [LAT];
  logic [LAT-1:0]           nv, ne, nl;

  assign out_valid = vq[LAT-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  assign acc      = mode ? in_ready : (in_valid & in_ready);
  assign acc_idx  = mode ? scan_cnt : sel;
  assign acc_err  = {1'b0, acc_idx} >= NUM_IN_X;
  assign acc_last = mode & (acc_idx == LAST_IDX);

  always_comb begin
    pad = '0;
    for (int k = 0; k < NUM_IN; k++)
      pad[k*WIDTH +: WIDTH] = in_data[k*WIDTH +: WIDTH];
  end

  // Next-state of every stage; the whole pipe advances together when not
  // stalled (rigid shift register, bubbles kept).
  always_comb begin
    for (int s = 0; s < LAT; s++) begin
      nd[s] = '0;
      ni[s] = '0;
    end
    nv = '0;
    ne = '0;
    nl = '0;

    nd[0] = reduce(pad, acc_idx, 0,
                   (LEVELS_PER_STAGE < SEL_W) ? LEVELS_PER_STAGE : SEL_W);
    ni[0] = acc_idx;
    nv[0] = acc;
    ne[0] = acc_err;
    nl[0] = acc_last;

    for (int s = 1; s < LAT; s++) begin
      nd[s] = reduce(dq[s-1], iq[s-1], s * LEVELS_PER_STAGE,
                     ((s + 1) * LEVELS_PER_STAGE < SEL_W) ? (s + 1) * LEVELS_PER_STAGE : SEL_W);
      ni[s] = iq[s-1];
      nv[s] = vq[s-1];
      ne[s] = eq[s-1];
      nl[s] = lq[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        dq[s] <= '0;
        iq[s] <= '0;
      end
      vq <= '0;
      eq <= '0;
      lq <= '0;
    end else if (!stall) begin
      dq <= nd;
      iq <= ni;
      vq <= nv;
      eq <= ne;
      lq <= nl;
    end
  end

  // Scan counter: cleared whenever direct mode is selected, so every scan
  // run starts from channel 0.
  always_ff @(posedge clk) begin
    if (rst || !mode)
      scan_cnt <= '0;
    else if (acc)
      scan_cnt <= (scan_cnt == LAST_IDX) ? '0 : scan_cnt + 1'b1;
  end

  assign out_data = dq[LAT-1][WIDTH-1:0];
  assign out_sel  = iq[LAT-1];
  assign out_err  = eq[LAT-1];
  assign out_last = lq[LAT-1];

endmodule

// File: tb/tb_mux_pipe_scan.sv
// -----------------------------------------------------------------------------
// tb_mux_pipe_scan
//   Four instances share one stimulus stream:
//     0: NUM_IN=64 WIDTH=8 LPS=2 (LAT 3)    1: NUM_IN=48 WIDTH=4 LPS=2 (LAT 3)
//     2: NUM_IN=64 WIDTH=8 LPS=1 (LAT 6)    3: NUM_IN=64 WIDTH=8 LPS=6 (LAT 1)
//   Each has its own scoreboard queue filled on accept and drained on transfer.
// -----------------------------------------------------------------------------
module tb_mux_pipe_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic [5:0] sel = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       nostall = 1'b0;

  logic [7:0] ch_a [64];
  logic [3:0] ch_b [48];
  logic [511:0] din_a;
  logic [191:0] din_b;

  always_comb begin
    din_a = '0;
    din_b = '0;
    for (int k = 0; k < 64; k++) din_a[k*8 +: 8] = ch_a[k];
    for (int k = 0; k < 48; k++) din_b[k*4 +: 4] = ch_b[k];
  end

  logic       ir_a, ov_a, oe_a, ol_a;
  logic [7:0] od_a;
  logic [5:0] os_a;
  logic       ir_b, ov_b, oe_b, ol_b;
  logic [3:0] od_b;
  logic [5:0] os_b;
  logic       ir_c, ov_c, oe_c, ol_c;
  logic [7:0] od_c;
  logic [5:0] os_c;
  logic       ir_d, ov_d, oe_d, ol_d;
  logic [7:0] od_d;
  logic [5:0] os_d;

  mux_pipe_scan #(.NUM_IN(64), .WIDTH(8), .LEVELS_PER_STAGE(2)) u_a (
    .clk(clk), .rst(rst), .in_data(din_a), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(ir_a), .out_data(od_a), .out_sel(os_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_err(oe_a), .out_last(ol_a));

  mux_pipe_scan #(.NUM_IN(48), .WIDTH(4), .LEVELS_PER_STAGE(2)) u_b (
    .clk(clk), .rst(rst), .in_data(din_b), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(ir_b), .out_data(od_b), .out_sel(os_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_err(oe_b), .out_last(ol_b));

  mux_pipe_scan #(.NUM_IN(64), .WIDTH(8), .LEVELS_PER_STAGE(1)) u_c (
    .clk(clk), .rst(rst), .in_data(din_a), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(ir_c), .out_data(od_c), .out_sel(os_c),
    .out_valid(ov_c), .out_ready(out_ready), .out_err(oe_c), .out_last(ol_c));

  mux_pipe_scan #(.NUM_IN(64), .WIDTH(8), .LEVELS_PER_STAGE(6)) u_d (
    .clk(clk), .rst(rst), .in_data(din_a), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(ir_d), .out_data(od_d), .out_sel(os_d),
    .out_valid(ov_d), .out_ready(out_ready), .out_err(oe_d), .out_last(ol_d));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] cyc;
    logic        last;
    logic        err;
    logic [5:0]  idx;
    logic [7:0]  data;
  } ent_t;

  ent_t       sbq [4][$];
  int         scnt [4];
  logic       pv [4];
  logic       pr [4];
  logic [7:0] pd [4];
  logic [5:0] ps [4];
  int         nlast [4];
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_data(input int d, input int idx);
    if (d == 1) begin
      if (idx < 48) return {4'b0, ch_b[idx]};
      return 8'h00;
    end
    return ch_a[idx];
  endfunction

  task automatic sb_step(input int d, input int lat, input int nin,
                         input logic ir, input logic ov, input logic [7:0] od,
                         input logic [5:0] os, input logic oe, input logic ol);
    ent_t e;
    logic acc;
    int   idx;
    if (rst) begin
      sbq[d].delete();
      scnt[d] = 0;
      pv[d] = 1'b0;
      return;
    end
    if (pv[d] && !pr[d]) begin
      chk($sformatf("d%0d_hold_valid", d), ov, 1);
      chk($sformatf("d%0d_hold_data", d), od, pd[d]);
      chk($sformatf("d%0d_hold_sel", d), os, ps[d]);
    end
    chk($sformatf("d%0d_in_ready", d), ir, !(ov && !out_ready));
    if (ov && out_ready) begin
      chk($sformatf("d%0d_pop_nonempty", d), sbq[d].size() > 0, 1);
      if (sbq[d].size() > 0) begin
        e = sbq[d].pop_front();
        chk($sformatf("d%0d_data", d), od, e.data);
        chk($sformatf("d%0d_sel", d), os, e.idx);
        chk($sformatf("d%0d_err", d), oe, e.err);
        chk($sformatf("d%0d_last", d), ol, e.last);
        if (nostall) chk($sformatf("d%0d_latency", d), cyc - int'(e.cyc), lat);
      end
      if (ol) nlast[d]++;
    end
    acc = mode ? ir : (in_valid && ir);
    if (acc) begin
      idx    = mode ? scnt[d] : int'(sel);
      e.cyc  = cyc;
      e.idx  = idx[5:0];
      e.err  = idx >= nin;
      e.last = mode && (idx == nin - 1);
      e.data = exp_data(d, idx);
      sbq[d].push_back(e);
    end
    if (!mode) scnt[d] = 0;
    else if (acc) scnt[d] = (scnt[d] == nin - 1) ? 0 : scnt[d] + 1;
    pv[d] = ov;
    pr[d] = out_ready;
    pd[d] = od;
    ps[d] = os;
  endtask

  always @(negedge clk) begin
    sb_step(0, 3, 64, ir_a, ov_a, od_a, os_a, oe_a, ol_a);
    sb_step(1, 3, 48, ir_b, ov_b, {4'b0, od_b}, os_b, oe_b, ol_b);
    sb_step(2, 6, 64, ir_c, ov_c, od_c, os_c, oe_c, ol_c);
    sb_step(3, 1, 64, ir_d, ov_d, od_d, os_d, oe_d, ol_d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) ch_a[k] = 8'(k + 8'h40);
    for (int k = 0; k < 48; k++) ch_b[k] = 4'(k * 5 + 3);

    // reset values
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_out_data", od_a, 0);
    chk("rst_out_sel", os_a, 0);
    chk("rst_out_err", oe_a, 0);
    chk("rst_out_last", ol_a, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", ir_a, 1);
    tick();

    // direct select sweep, no back-pressure
    nostall = 1'b1;
    for (int k = 0; k < 64; k++) begin
      sel = 6'(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();

    // stall with held output
    nostall = 1'b0;
    sel = 6'd37;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 6'd5;
    repeat (4) begin
      @(negedge clk);
      chk("stall_out_valid", ov_a, 1);
      chk("stall_in_ready", ir_a, 0);
      chk("stall_out_data", od_a, 8'h65);
      chk("stall_out_sel", os_a, 37);
      tick();
    end
    out_ready = 1'b1;
    tick();
    sel = 6'd6;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();

    // scan mode, two full sweeps plus two items, then a restart
    for (int k = 0; k < 64; k++) ch_a[k] = ~8'(k);
    for (int k = 0; k < 48; k++) ch_b[k] = ~4'(k);
    for (int d = 0; d < 4; d++) nlast[d] = 0;
    nostall = 1'b1;
    mode = 1'b1;
    repeat (130) tick();
    mode = 1'b0;
    repeat (10) tick();
    for (int d = 0; d < 4; d++) chk($sformatf("d%0d_last_count", d), nlast[d], 2);
    mode = 1'b1;
    repeat (3) tick();
    mode = 1'b0;
    repeat (10) tick();
    nostall = 1'b0;

    // out-of-range index on the 48-channel instance, then the last valid one
    for (int k = 0; k < 48; k++) ch_b[k] = 4'(k * 5 + 3);
    sel = 6'd50;
    in_valid = 1'b1;
    tick();
    sel = 6'd47;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();

    // reset with a full, stalled pipeline
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin
      sel = 6'($urandom_range(0, 63));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", ir_a, 1);
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_valid_a", ov_a, 0);
      chk("post_rst_valid_b", ov_b, 0);
      chk("post_rst_valid_c", ov_c, 0);
      chk("post_rst_valid_d", ov_d, 0);
      tick();
    end

    // random traffic with random back-pressure and occasional scan bursts
    for (int k = 0; k < 64; k++) ch_a[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 48; k++) ch_b[k] = 4'($urandom_range(0, 15));
    repeat (800) begin
      mode      = ($urandom_range(0, 9) == 0);
      sel       = 6'($urandom_range(0, 63));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    mode = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    for (int d = 0; d < 4; d++) chk($sformatf("d%0d_drained", d), sbq[d].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
